// File: rtl/fpmul_pkg.sv
// Shared types and constants for the fpmul operand path: raw IEEE-754 single
// words and the A/B pair that travels through the operand FIFO.
package fpmul_pkg;
  localparam int FP_W = 32;

  typedef logic [FP_W-1:0] fp32_t;

  typedef struct packed {
    fp32_t a;
    fp32_t b;
  } fp_pair_t;

  localparam fp32_t FP_ONE = 32'h3F80_0000;
  localparam fp32_t FP_TWO = 32'h4000_0000;
endpackage

// File: rtl/fpmul_operand_fifo_if.sv
// One valid/ready stream carrying an operand pair (a, b).
// A beat transfers on a rising edge where valid && ready; while valid is high
// and ready is low, the master holds valid, a and b unchanged.
interface fpmul_operand_fifo_if import fpmul_pkg::*; #(
  parameter int FP_W = fpmul_pkg::FP_W
);
  logic            valid;
  logic            ready;
  logic [FP_W-1:0] a;
  logic [FP_W-1:0] b;

  modport master (output valid, a, b, input ready);
  modport slave  (input valid, a, b, output ready);
endinterface

// File: rtl/fpmul_pair_ram.sv
// Operand-pair storage: one synchronous write port, one asynchronous read port.
// Contents are never cleared; validity is tracked by the FIFO pointers.
module fpmul_pair_ram import fpmul_pkg::*; #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     we,
  input  logic [AW-1:0] waddr,
  input  fp_pair_t wdata,
  input  logic [AW-1:0] raddr,
  output fp_pair_t rdata
);
  fp_pair_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fpmul_operand_fifo.sv
// First-word-fall-through FIFO of operand pairs feeding the fpmul wrapper,
// with occupancy and accepted-pair counters.
module fpmul_operand_fifo #(
  parameter int DEPTH = 8,
  parameter int FP_W  = fpmul_pkg::FP_W,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  fpmul_operand_fifo_if.slave    s,
  fpmul_operand_fifo_if.master   m,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       accepted,
  output logic                   full,
  output logic                   empty
);
  import fpmul_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] ACC_ONE = 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fpmul_operand_fifo: DEPTH must be a power of two >= 2");
  end
  if (FP_W != $bits(fp32_t)) begin : g_bad_fp_w
    $error("fpmul_operand_fifo: FP_W must match fp32_t");
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push;
  logic        pop;
  fp_pair_t    wr_pair;
  fp_pair_t    rd_pair;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Ready/valid come from registered pointers only, never from the peer's signals.
  assign s.ready = !full;
  assign m.valid = !empty;

  assign push = s.valid && !full;
  assign pop  = m.ready && !empty;

  assign wr_pair = '{a: s.a, b: s.b};
  assign m.a     = rd_pair.a;
  assign m.b     = rd_pair.b;

  fpmul_pair_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_pair),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_pair)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      accepted <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_ONE;
        accepted <= accepted + ACC_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + PTR_ONE;
        2'b01:   count <= count - PTR_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule
